// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined
//   ARM decode stage with an integrated ID/EX pipeline register.
//   Decodes the instruction, checks its condition against NZCV and reads two
//   operands from an internal register file (optional same-cycle write-back
//   bypass). hazard/flush load a bubble into the ID/EX register.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid, pc_in, instruction   IF/ID slot contents
//   hazard, flush            bubble requests
//   z, c, v, n               status flags
//   wb_wb_en, wb_dest, wb_value    register-file write port
//   src1, src2, two_src      combinational source info for the hazard unit
//   out_valid .. shift_operand     registered ID/EX outputs
module id_stage_pipelined #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 16,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic [31:0]           instruction,
  input  logic                  hazard,
  input  logic                  flush,
  input  logic                  z,
  input  logic                  c,
  input  logic                  v,
  input  logic                  n,
  input  logic                  wb_wb_en,
  input  logic [3:0]            wb_dest,
  input  logic [DATA_WIDTH-1:0] wb_value,
  output logic [3:0]            src1,
  output logic [3:0]            src2,
  output logic                  two_src,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  s,
  output logic                  b,
  output logic                  mem_w_en,
  output logic                  mem_r_en,
  output logic                  wb_en,
  output logic [3:0]            exe_cmd,
  output logic [DATA_WIDTH-1:0] val_rn,
  output logic [DATA_WIDTH-1:0] val_rm,
  output logic                  imm,
  output logic [23:0]           signed_imm_24,
  output logic [3:0]            dest,
  output logic [11:0]           shift_operand
);

  logic [3:0] cond;
  logic [1:0] mode;
  logic       i_bit;
  logic [3:0] opcode;
  logic       s_bit;
  logic       is_store;

  assign cond     = instruction[31:28];
  assign mode     = instruction[27:26];
  assign i_bit    = instruction[25];
  assign opcode   = instruction[24:21];
  assign s_bit    = instruction[20];
  assign is_store = (mode == 2'b01) && !s_bit;

  assign src1    = instruction[19:16];
  assign src2    = is_store ? instruction[15:12] : instruction[3:0];
  assign two_src = !i_bit || is_store;

  // Condition evaluation
  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Control decode
  logic       dec_s, dec_b, dec_mem_w_en, dec_mem_r_en, dec_wb_en;
  logic [3:0] dec_cmd;
  always_comb begin
    dec_s        = 1'b0;
    dec_b        = 1'b0;
    dec_mem_w_en = 1'b0;
    dec_mem_r_en = 1'b0;
    dec_wb_en    = 1'b0;
    dec_cmd      = 4'b0000;
    case (mode)
      2'b00: begin
        dec_s     = s_bit;
        dec_wb_en = 1'b1;
        case (opcode)
          4'b1101: dec_cmd = 4'b0001;
          4'b1111: dec_cmd = 4'b1001;
          4'b0100: dec_cmd = 4'b0010;
          4'b0101: dec_cmd = 4'b0011;
          4'b0010: dec_cmd = 4'b0100;
          4'b0110: dec_cmd = 4'b0101;
          4'b0000: dec_cmd = 4'b0110;
          4'b1100: dec_cmd = 4'b0111;
          4'b0001: dec_cmd = 4'b1000;
          4'b1010: begin dec_cmd = 4'b0100; dec_wb_en = 1'b0; end
          4'b1000: begin dec_cmd = 4'b0110; dec_wb_en = 1'b0; end
          default: begin dec_cmd = 4'b0000; dec_wb_en = 1'b0; end
        endcase
      end
      2'b01: begin
        dec_cmd = 4'b0010;
        if (s_bit) begin
          dec_mem_r_en = 1'b1;
          dec_wb_en    = 1'b1;
        end else begin
          dec_mem_w_en = 1'b1;
        end
      end
      2'b10:   dec_b = 1'b1;
      default: ;
    endcase
  end

  // Register file; indices >= REG_COUNT have no storage
  logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (rst) begin
        rf_q[i] <= '0;
      end else if (wb_wb_en && (wb_dest == 4'(i))) begin
        rf_q[i] <= wb_value;
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_rn, rd_rm;
  logic                  hit_rn, hit_rm;
  always_comb begin
    rd_rn  = '0;
    rd_rm  = '0;
    hit_rn = 1'b0;
    hit_rm = 1'b0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (src1 == 4'(i)) begin
        rd_rn  = rf_q[i];
        hit_rn = 1'b1;
      end
      if (src2 == 4'(i)) begin
        rd_rm  = rf_q[i];
        hit_rm = 1'b1;
      end
    end
    // Bypass only for implemented indices, so an out-of-range read stays 0
    if (BYPASS != 0 && wb_wb_en) begin
      if (hit_rn && wb_dest == src1) rd_rn = wb_value;
      if (hit_rm && wb_dest == src2) rd_rm = wb_value;
    end
  end

  // ID/EX register
  logic issue;
  assign issue = in_valid && cond_pass;

  always_ff @(posedge clk) begin
    if (rst || flush || hazard) begin
      out_valid     <= 1'b0;
      pc_out        <= '0;
      s             <= 1'b0;
      b             <= 1'b0;
      mem_w_en      <= 1'b0;
      mem_r_en      <= 1'b0;
      wb_en         <= 1'b0;
      exe_cmd       <= 4'b0000;
      val_rn        <= '0;
      val_rm        <= '0;
      imm           <= 1'b0;
      signed_imm_24 <= '0;
      dest          <= 4'b0000;
      shift_operand <= '0;
    end else begin
      out_valid     <= issue;
      pc_out        <= pc_in;
      s             <= dec_s && issue;
      b             <= dec_b && issue;
      mem_w_en      <= dec_mem_w_en && issue;
      mem_r_en      <= dec_mem_r_en && issue;
      wb_en         <= dec_wb_en && issue;
      exe_cmd       <= dec_cmd & {4{issue}};
      val_rn        <= rd_rn;
      val_rm        <= rd_rm;
      imm           <= i_bit;
      signed_imm_24 <= instruction[23:0];
      dest          <= instruction[15:12];
      shift_operand <= instruction[11:0];
    end
  end

endmodule
